// File: rtl/imm_encoder.sv
// imm_encoder: two-stage valid/ready pipeline that packs a RISC-V style
// immediate into the instruction bit field [31:7] (data[i] = instruction bit i+7)
// and flags immediates that are not representable in the selected format.
// Optional feature: define IMM_ENC_ERRCNT_EN to add the saturating err_count
// output, which counts error results as they are handed to the consumer.
module imm_encoder #(
    parameter logic [2:0] I_type = 3'd0,
    parameter logic [2:0] S_type = 3'd1,
    parameter logic [2:0] B_type = 3'd2,
    parameter logic [2:0] J_type = 3'd3,
    parameter logic [2:0] U_type = 3'd4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  immSrc,
    input  logic [31:0] imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [24:0] data,
    output logic        imm_err
`ifdef IMM_ENC_ERRCNT_EN
    ,
    output logic [15:0] err_count
`endif
);

    logic        s1_valid;
    logic [2:0]  s1_src;
    logic [31:0] s1_imm;
    logic        s2_valid;
    logic        s2_load;
    logic        in_fire;
    logic [24:0] pk_data;
    logic        pk_err;

    // true when every bit of the slice matches (sign-extension check)
    function automatic logic all_eq(input logic [20:0] v, input int unsigned n);
        logic ones;
        logic zeros;
        ones  = 1'b1;
        zeros = 1'b1;
        for (int unsigned i = 0; i < 21; i++) begin
            if (i < n) begin
                ones  = ones & v[i];
                zeros = zeros & ~v[i];
            end
        end
        return ones | zeros;
    endfunction

    // handshake: stage 2 loads when it is empty or draining this cycle
    always_comb begin
        s2_load  = s1_valid && (!s2_valid || out_ready);
        in_ready = !s1_valid || s2_load;
        in_fire  = in_valid && in_ready;
    end

    assign out_valid = s2_valid;

    // format packing and representability check on the stage-1 request
    always_comb begin
        pk_data = '0;
        pk_err  = 1'b0;
        case (s1_src)
            I_type: begin
                pk_data[24:13] = s1_imm[11:0];
                pk_err         = !all_eq(s1_imm[31:11], 21);
            end
            S_type: begin
                pk_data[24:18] = s1_imm[11:5];
                pk_data[4:0]   = s1_imm[4:0];
                pk_err         = !all_eq(s1_imm[31:11], 21);
            end
            B_type: begin
                pk_data[24]    = s1_imm[12];
                pk_data[23:18] = s1_imm[10:5];
                pk_data[4:1]   = s1_imm[4:1];
                pk_data[0]     = s1_imm[11];
                pk_err         = !all_eq({1'b0, s1_imm[31:12]}, 20) || s1_imm[0];
            end
            J_type: begin
                pk_data[24]    = s1_imm[20];
                pk_data[23:14] = s1_imm[10:1];
                pk_data[13]    = s1_imm[11];
                pk_data[12:5]  = s1_imm[19:12];
                pk_err         = !all_eq({9'd0, s1_imm[31:20]}, 12) || s1_imm[0];
            end
            U_type: begin
                pk_data[24:5]  = s1_imm[31:12];
                pk_err         = (s1_imm[11:0] != 12'd0);
            end
            default: begin
                pk_data = '0;
                pk_err  = 1'b1;
            end
        endcase
    end

    // stage 1: capture the raw request on an input transfer
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_src   <= '0;
            s1_imm   <= '0;
        end else begin
            if (in_fire) begin
                s1_src <= immSrc;
                s1_imm <= imm;
            end
            if (in_fire) begin
                s1_valid <= 1'b1;
            end else if (s2_load) begin
                s1_valid <= 1'b0;
            end
        end
    end

    // stage 2: registered result, held while the consumer stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
            data     <= '0;
            imm_err  <= 1'b0;
        end else begin
            if (s2_load) begin
                s2_valid <= 1'b1;
                data     <= pk_data;
                imm_err  <= pk_err;
            end else if (out_ready) begin
                s2_valid <= 1'b0;
            end
        end
    end

`ifdef IMM_ENC_ERRCNT_EN
    // saturating count of error results handed to the consumer
    always_ff @(posedge clk) begin
        if (rst) begin
            err_count <= '0;
        end else if (s2_valid && out_ready && imm_err && (err_count != 16'hFFFF)) begin
            err_count <= err_count + 16'd1;
        end
    end
`endif

endmodule

// File: doc/imm_encoder.md
IMM_ENCODER -- requirements
Module: imm_encoder

Interface
REQ-001 SHALL have parameters I_type=0, S_type=1, B_type=2, J_type=3, U_type=4, each 3 bits wide, selecting the immediate format code.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1 bit: the request is valid.
REQ-005 SHALL have port in_ready, output, 1 bit: the block can accept a request.
REQ-006 SHALL have port immSrc, input, 3 bits: the format code of the request.
REQ-007 SHALL have port imm, input, 32 bits: the signed or raw immediate to pack.
REQ-008 SHALL have port out_valid, output, 1 bit: the result is valid.
REQ-009 SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-010 SHALL have port data, output, 25 bits: the packed field, where data[i] corresponds to instruction bit i+7.
REQ-011 SHALL have port imm_err, output, 1 bit: the immediate is not representable in the selected format (see REQ-017).
REQ-012 SHALL have port err_count, output, 16 bits: present only when IMM_ENC_ERRCNT_EN is defined.

Function
REQ-013 SHALL pack I_type as data[24:13]=imm[11:0], with all other data bits 0.
REQ-014 SHALL pack S_type as data[24:18]=imm[11:5] and data[4:0]=imm[4:0], with all other bits 0.
REQ-015 SHALL pack B_type as data[24]=imm[12], data[23:18]=imm[10:5], data[4:1]=imm[4:1] and data[0]=imm[11], with all other bits 0.
REQ-016 SHALL pack J_type as data[24]=imm[20], data[23:14]=imm[10:1], data[13]=imm[11] and data[12:5]=imm[19:12], with data[4:0]=0; SHALL pack U_type as data[24:5]=imm[31:12] and data[4:0]=0.
REQ-017 SHALL set imm_err under these conditions:
- I/S: imm[31:11] not all equal.
- B: imm[31:12] not all equal, or imm[0]=1.
- J: imm[31:20] not all equal, or imm[0]=1.
- U: imm[11:0]≠0.
- immSrc 5–7: always; data=0.
REQ-018 On imm_err from a range, sign or alignment violation, SHALL still output the truncated packing.
REQ-019 SHALL be a two-stage pipeline:
- Stage 1 captures {immSrc, imm}.
- Stage 2 holds the registered {data, imm_err}.
- Latency is 2 cycles from the in_valid&in_ready edge to out_valid.
REQ-020 SHALL define a transfer as valid&ready high at a rising edge.
REQ-021 Each stage SHALL advance when downstream is empty or being drained in the same cycle.
REQ-022 in_ready SHALL be !s1_valid || s1 advancing, computed combinationally from out_ready.
REQ-023 Throughput SHALL be 1 request/cycle while out_ready=1.
REQ-024 While out_valid=1 and out_ready=0, data, imm_err and out_valid SHALL remain stable.
REQ-025 With both stages full and out_ready=0, in_ready SHALL be 0 and no request SHALL be lost or duplicated.
REQ-026 Simultaneous input and output transfers on a full pipeline SHALL shift both stages in the same edge.
REQ-027 Results SHALL appear in acceptance order.

Reset
REQ-028 When rst=1 at a clock edge, both stage-valid flags, data, imm_err and err_count SHALL reset to 0.
REQ-029 in_ready SHALL read 1 in the first cycle after reset.
REQ-030 A reset mid-operation SHALL discard in-flight requests without emitting them.
REQ-031 rst SHALL take priority over any concurrent transfer.

Configuration
REQ-032 With macro IMM_ENC_ERRCNT_EN defined, err_count SHALL increment by 1 on each output transfer with imm_err=1, and SHALL saturate at 16'hFFFF.
REQ-033 Without IMM_ENC_ERRCNT_EN, the err_count port and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-034 I_type, imm=32'hFFFF_F800, out_ready=1 -> 2 cycles later data[24:13]=12'h800, other bits 0, imm_err=0.
REQ-035 B_type imm=32'h0000_0FFE -> data[24]=0, data[23:18]=6'h3F, data[4:1]=4'hF, data[0]=1, imm_err=0; then imm=32'h0000_0003 -> imm_err=1.
REQ-036 J_type imm=32'h000F_F002 and U_type imm=32'h1234_5000 -> J: data[12:5]=8'hFF, data[14]=1, data[13]=0; U: data[24:5]=20'h12345, imm_err=0.
REQ-037 Stream 6 back-to-back requests with out_ready low for cycles 3–5 -> in_ready drops after 2 accepted-but-unconsumed requests; all 6 results emerge in order, none dropped, outputs stable while stalled.
REQ-038 Assert rst with both stages full -> next cycle out_valid=0, in_ready=1, err_count=0; pre-reset requests never appear.
REQ-039 With IMM_ENC_ERRCNT_EN, send 3 requests with immSrc=7 -> err_count=3 after the third output transfer; counter preloaded to 16'hFFFF stays at 16'hFFFF.
